// File: rtl/lift_scan_controller.sv
// lift_scan_controller
//   Parametrised N-floor lift controller. Car and hall calls are latched into
//   request registers and served with a LOOK scheduler. The controller drives
//   the motor, door and direction outputs from the floor and inter-floor sensors.
//   It also provides door hold/reopen, a travel watchdog, a sticky fault on
//   inconsistent floor sensors, and idle parking at HOME_FLOOR.
//
// Ports
//   clk, rst_n             clock; asynchronous active-low reset
//   i_l / i_u / i_d [N]    car-panel, hall-up and hall-down call inputs
//   sf [N], si [N-1]       floor sensors (one-hot when level), inter-floor sensors
//   hold                   door-open button / obstruction
//   motor_up, motor_dn     motor drive (only in MOVE)
//   door_open              door command (only in DOOR)
//   dir_up                 current scan direction
//   cur_floor              last valid floor seen on sf
//   car_req/up_req/dn_req  pending request registers
//   fault                  sticky fault flag (cleared only by rst_n)
module lift_scan_controller #(
  parameter int N            = 8,
  parameter int DOOR_CYCLES  = 5_000_000,
  parameter int MOVE_TIMEOUT = 50_000_000,
  parameter int PARK_CYCLES  = 100_000_000,
  parameter int HOME_FLOOR   = 0,
  localparam int FW          = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_l,
  input  logic [N-1:0]  i_u,
  input  logic [N-1:0]  i_d,
  input  logic [N-1:0]  sf,
  input  logic [N-2:0]  si,
  input  logic          hold,
  output logic          motor_up,
  output logic          motor_dn,
  output logic          door_open,
  output logic          dir_up,
  output logic [FW-1:0] cur_floor,
  output logic [N-1:0]  car_req,
  output logic [N-1:0]  up_req,
  output logic [N-1:0]  dn_req,
  output logic          fault
);

  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int WW = (MOVE_TIMEOUT > 1) ? $clog2(MOVE_TIMEOUT) : 1;
  localparam int PW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
  localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_CYCLES - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(MOVE_TIMEOUT - 1);
  localparam logic [PW-1:0] PARK_LAST = PW'((PARK_CYCLES > 0) ? PARK_CYCLES - 1 : 0);
  localparam logic [FW-1:0] HOME      = FW'(HOME_FLOOR);
  localparam logic [FW-1:0] TOP       = FW'(N - 1);
  localparam logic [N-1:0]  TOP_BIT   = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  BOT_BIT   = N'(1);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR, FAULT} state_t;

  state_t          state, state_n;
  logic [DW-1:0]   door_cnt;
  logic [WW-1:0]   wd_cnt;
  logic [PW-1:0]   park_cnt;

  logic            seen, multi, v;
  logic [FW-1:0]   sf_idx, ref_floor;
  logic [N-1:0]    up_in, dn_in, calls_in, any_req;
  logic            ahead_up, ahead_dn, ahead_dir;
  logic            at_car, at_any, match_hall, opp_hall;
  logic            arrival, at_end, call_here;
  logic            enter_door, door_flip, idle_flip, park_fire;
  logic [N-1:0]    car_n, up_n, dn_n;

  // Sensor decode: multi flags an impossible multi-floor reading.
  always_comb begin
    seen   = 1'b0;
    multi  = 1'b0;
    sf_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (sf[k]) begin
        if (seen) multi = 1'b1;
        seen   = 1'b1;
        sf_idx = FW'(k);
      end
    end
    v = seen & ~multi & (si == '0);
  end

  assign up_in    = i_u & ~TOP_BIT;
  assign dn_in    = i_d & ~BOT_BIT;
  assign calls_in = i_l | up_in | dn_in;
  assign any_req  = car_req | up_req | dn_req;

  // While moving, scheduling decisions refer to the floor being arrived at;
  // otherwise to the floor the car is standing at.
  assign ref_floor = (state == MOVE) ? sf_idx : cur_floor;

  always_comb begin
    ahead_up = 1'b0;
    ahead_dn = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k > int'(ref_floor)) ahead_up = ahead_up | any_req[k];
      if (k < int'(ref_floor)) ahead_dn = ahead_dn | any_req[k];
    end
  end

  assign ahead_dir  = dir_up ? ahead_up : ahead_dn;
  assign at_car     = car_req[ref_floor];
  assign at_any     = any_req[ref_floor];
  assign match_hall = dir_up ? up_req[ref_floor] : dn_req[ref_floor];
  assign opp_hall   = dir_up ? dn_req[ref_floor] : up_req[ref_floor];
  assign arrival    = v & (sf_idx != cur_floor);
  assign at_end     = dir_up ? (sf_idx == TOP) : (sf_idx == '0);
  assign call_here  = calls_in[cur_floor];

  // Turning around at the door when nothing is ahead. Also, when a stationary
  // car opens only for an opposite-direction hall call, it turns to serve that
  // call; otherwise the call would never be cleared and the door would recycle.
  assign door_flip = ~ahead_dir | ((state == IDLE) & ~match_hall & opp_hall);
  assign idle_flip = (state == IDLE) & (state_n == MOVE) & ~ahead_dir;
  assign park_fire = (PARK_CYCLES != 0) && (state == IDLE) && (any_req == '0) &&
                     (park_cnt == PARK_LAST) && (cur_floor != HOME);

  // Next-state and Moore outputs.
  always_comb begin
    state_n    = state;
    enter_door = 1'b0;
    motor_up   = 1'b0;
    motor_dn   = 1'b0;
    door_open  = 1'b0;
    fault      = 1'b0;
    case (state)
      IDLE: begin
        if (at_any) begin
          state_n    = DOOR;
          enter_door = 1'b1;
        end else if (any_req != '0) begin
          state_n = MOVE;
        end
      end
      MOVE: begin
        motor_up = dir_up;
        motor_dn = ~dir_up;
        if (arrival & (at_car | match_hall | (opp_hall & ~ahead_dir) | at_end)) begin
          if (at_any) begin
            state_n    = DOOR;
            enter_door = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (~arrival && (wd_cnt == WD_LAST)) begin
          state_n = FAULT;
        end
      end
      DOOR: begin
        door_open = 1'b1;
        if (~(hold | call_here) && (door_cnt == DOOR_LAST)) state_n = IDLE;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: state_n = FAULT;
    endcase
    if (multi) begin
      state_n    = FAULT;
      enter_door = 1'b0;
    end
  end

  // Request update: new calls OR in, except calls at the open-door floor.
  // Service clears applied last so they win on the door-entry cycle.
  always_comb begin
    car_n = car_req | i_l;
    up_n  = up_req | up_in;
    dn_n  = dn_req | dn_in;
    if (state == DOOR) begin
      car_n = car_req | (i_l & ~(N'(1) << cur_floor));
      up_n  = up_req | (up_in & ~(N'(1) << cur_floor));
      dn_n  = dn_req | (dn_in & ~(N'(1) << cur_floor));
    end
    if (park_fire) car_n[HOME_FLOOR] = 1'b1;
    if (enter_door) begin
      car_n[ref_floor] = 1'b0;
      if (dir_up | door_flip)  up_n[ref_floor] = 1'b0;
      if (~dir_up | door_flip) dn_n[ref_floor] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dir_up    <= 1'b1;
      cur_floor <= '0;
      car_req   <= '0;
      up_req    <= '0;
      dn_req    <= '0;
    end else begin
      state <= state_n;
      if (v) cur_floor <= sf_idx;
      if (idle_flip || (enter_door && door_flip)) dir_up <= ~dir_up;
      if (state != FAULT) begin
        car_req <= car_n;
        up_req  <= up_n;
        dn_req  <= dn_n;
      end
    end
  end

  // Door, watchdog and park counters; each restarts from 0 when its state is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_cnt <= '0;
      wd_cnt   <= '0;
      park_cnt <= '0;
    end else begin
      if (state == DOOR && !(hold || call_here)) door_cnt <= door_cnt + 1'b1;
      else                                       door_cnt <= '0;

      if (state == MOVE && state_n == MOVE && !arrival) wd_cnt <= wd_cnt + 1'b1;
      else                                              wd_cnt <= '0;

      if (PARK_CYCLES != 0 && state == IDLE && any_req == '0)
        park_cnt <= (park_cnt == PARK_LAST) ? '0 : park_cnt + 1'b1;
      else
        park_cnt <= '0;
    end
  end

endmodule
